// File: rtl/whistle_command_decoder.sv
// whistle_command_decoder: groups above-threshold pitch frames into whistle events
// and presents each classified event (SHORT/LONG/RISING/FALLING) on a valid/ready port.
`default_nettype none

module whistle_command_decoder #(
  parameter int NSamples       = 256,
  parameter int THRESHOLD      = 50,
  parameter int MIN_FRAMES     = 3,
  parameter int LONG_FRAMES    = 20,
  parameter int GAP_FRAMES     = 2,
  parameter int SLIDE_DELTA    = 8,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int KW            = $clog2(NSamples)
) (
  input  logic          fft_clk,
  input  logic          reset,
  input  logic [KW-1:0] pitch_data,
  input  logic          pitch_valid,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [1:0]    cmd_code,
  output logic [7:0]    cmd_frames,
  output logic          whistle_active,
  output logic          overflow
);

  localparam int GW = $clog2(GAP_FRAMES + 2);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] CODE_SHORT   = 2'd0;
  localparam logic [1:0] CODE_LONG    = 2'd1;
  localparam logic [1:0] CODE_RISING  = 2'd2;
  localparam logic [1:0] CODE_FALLING = 2'd3;
  localparam logic signed [KW:0] SLIDE = (KW+1)'(SLIDE_DELTA);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [KW-1:0] first_bin, first_bin_n;
  logic [KW-1:0] last_bin, last_bin_n;
  logic [7:0]    run, run_n;
  logic [GW-1:0] gap, gap_n, gap_inc;
  logic [TW-1:0] tmo, tmo_n;
  logic          evt_end;

  logic              hit, miss, new_cmd;
  logic signed [KW:0] diff;
  logic [1:0]        code_n;

  assign hit     = pitch_valid && (pitch_data > KW'(THRESHOLD));
  assign miss    = pitch_valid && !hit;
  assign gap_inc = gap + 1'b1;

  always_comb begin
    state_n     = state;
    first_bin_n = first_bin;
    last_bin_n  = last_bin;
    run_n       = run;
    gap_n       = gap;
    tmo_n       = tmo;
    evt_end     = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          state_n     = ACTIVE;
          first_bin_n = pitch_data;
          last_bin_n  = pitch_data;
          run_n       = 8'd1;
          gap_n       = '0;
          tmo_n       = '0;
        end
      end
      ACTIVE: begin
        if (pitch_valid) begin
          tmo_n = '0;
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          evt_end = 1'b1;
        end else begin
          tmo_n = tmo + 1'b1;
        end
        if (hit) begin
          run_n      = (run == 8'hFF) ? run : run + 8'd1;
          last_bin_n = pitch_data;
          gap_n      = '0;
        end else if (miss) begin
          gap_n = gap_inc;
          if (gap_inc > GW'(GAP_FRAMES)) evt_end = 1'b1;
        end
        // The terminating frame is a miss or a timeout, so it can never open a new event.
        if (evt_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign diff    = $signed({1'b0, last_bin}) - $signed({1'b0, first_bin});
  assign new_cmd = evt_end && (run >= 8'(MIN_FRAMES));

  always_comb begin
    code_n = CODE_SHORT;
    if (diff >= SLIDE)                  code_n = CODE_RISING;
    else if (diff <= -SLIDE)            code_n = CODE_FALLING;
    else if (run >= 8'(LONG_FRAMES))    code_n = CODE_LONG;
  end

  always_ff @(posedge fft_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      first_bin <= '0;
      last_bin  <= '0;
      run       <= '0;
      gap       <= '0;
      tmo       <= '0;
    end else begin
      state     <= state_n;
      first_bin <= first_bin_n;
      last_bin  <= last_bin_n;
      run       <= run_n;
      gap       <= gap_n;
      tmo       <= tmo_n;
    end
  end

  // A pending, unaccepted command wins over a new one; the loser is flagged.
  always_ff @(posedge fft_clk or posedge reset) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      cmd_frames <= '0;
      overflow   <= 1'b0;
    end else begin
      if (new_cmd && cmd_valid && !cmd_ready) begin
        overflow <= 1'b1;
      end else if (new_cmd) begin
        cmd_valid  <= 1'b1;
        cmd_code   <= code_n;
        cmd_frames <= run;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign whistle_active = (state == ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_whistle_command_decoder.sv
// tb_whistle_command_decoder: table-driven whistle vectors plus directed multi-cycle sequences.
`default_nettype none

module tb_whistle_command_decoder;

  localparam int TIMEOUT = 65536;

  logic       fft_clk = 1'b0;
  logic       reset;
  logic [7:0] pitch_data;
  logic       pitch_valid;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic [7:0] cmd_frames;
  logic       whistle_active;
  logic       overflow;

  int tests  = 0;
  int failed = 0;

  whistle_command_decoder dut (
    .fft_clk        (fft_clk),
    .reset          (reset),
    .pitch_data     (pitch_data),
    .pitch_valid    (pitch_valid),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_code       (cmd_code),
    .cmd_frames     (cmd_frames),
    .whistle_active (whistle_active),
    .overflow       (overflow)
  );

  always #5 fft_clk = ~fft_clk;

  typedef struct {
    int n;
    int start;
    int step;
    int exp_act;
    int exp_valid;
    int exp_code;
    int exp_frames;
  } vec_t;

  vec_t vecs[14];

  task automatic cyc();
    @(posedge fft_clk);
    #1;
  endtask

  task automatic frame(input int bin);
    pitch_valid = 1'b1;
    pitch_data  = 8'(bin);
    cyc();
    pitch_valid = 1'b0;
  endtask

  task automatic hits(input int n, input int bin);
    for (int i = 0; i < n; i++) begin
      frame(bin);
      cyc();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic misses3();
    frame(10); cyc();
    frame(10); cyc();
    frame(10);
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    cyc();
    cmd_ready = 1'b0;
  endtask

  initial begin
    int k;
    //        n   start step act valid code frames
    vecs[0]  = '{5,   60,   0,  1,  1,   0,   5};
    vecs[1]  = '{25,  70,   0,  1,  1,   1,   25};
    vecs[2]  = '{300, 70,   0,  1,  1,   1,   255};
    vecs[3]  = '{5,   55,   3,  1,  1,   2,   5};
    vecs[4]  = '{5,   90,  -2,  1,  1,   3,   5};
    vecs[5]  = '{5,   90,  -3,  1,  1,   3,   5};
    vecs[6]  = '{2,   60,   0,  1,  0,   0,   0};
    vecs[7]  = '{5,   50,   0,  0,  0,   0,   0};
    vecs[8]  = '{3,   60,   0,  1,  1,   0,   3};
    vecs[9]  = '{20,  60,   0,  1,  1,   1,   20};
    vecs[10] = '{19,  60,   0,  1,  1,   0,   19};
    vecs[11] = '{8,   60,   1,  1,  1,   0,   8};
    vecs[12] = '{9,   60,   1,  1,  1,   2,   9};
    vecs[13] = '{25,  60,   1,  1,  1,   2,   25};

    reset = 1'b1; pitch_valid = 1'b0; pitch_data = '0; cmd_ready = 1'b0;
    cyc(); cyc();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_frames", cmd_frames, 0);
    check("rst_active", whistle_active, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    cyc();

    for (int v = 0; v < 14; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        frame(vecs[v].start + i * vecs[v].step);
        cyc();
      end
      check($sformatf("v%0d_active", v), whistle_active, vecs[v].exp_act);
      misses3();
      check($sformatf("v%0d_valid", v), cmd_valid, vecs[v].exp_valid);
      check($sformatf("v%0d_active_end", v), whistle_active, 0);
      if (vecs[v].exp_valid != 0) begin
        check($sformatf("v%0d_code", v), cmd_code, vecs[v].exp_code);
        check($sformatf("v%0d_frames", v), cmd_frames, vecs[v].exp_frames);
      end
      accept();
      check($sformatf("v%0d_valid_after", v), cmd_valid, 0);
      cyc();
    end
    check("table_overflow", overflow, 0);

    // Gap tolerance: two misses inside the whistle do not split it.
    hits(4, 60);
    frame(10); cyc(); frame(10); cyc();
    check("gap_active", whistle_active, 1);
    check("gap_no_cmd", cmd_valid, 0);
    hits(4, 60);
    misses3();
    check("gap_valid", cmd_valid, 1);
    check("gap_frames", cmd_frames, 8);
    check("gap_code", cmd_code, 0);

    // Second command while the first is held -> dropped, overflow sticky.
    cyc();
    hits(25, 60);
    misses3();
    cyc();
    check("ovf_valid", cmd_valid, 1);
    check("ovf_frames_held", cmd_frames, 8);
    check("ovf_code_held", cmd_code, 0);
    check("ovf_flag", overflow, 1);
    accept();
    check("ovf_valid_after", cmd_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset clears overflow; then accept and load on the same cycle.
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    check("rst2_overflow", overflow, 0);
    hits(5, 60);
    misses3();
    cyc();
    hits(25, 60);
    frame(10); cyc(); frame(10); cyc();
    cmd_ready = 1'b1;
    frame(10);
    cmd_ready = 1'b0;
    check("swap_valid", cmd_valid, 1);
    check("swap_code", cmd_code, 1);
    check("swap_frames", cmd_frames, 25);
    check("swap_overflow", overflow, 0);
    accept();
    check("swap_valid_after", cmd_valid, 0);

    // Timeout: the event is forced to end after TIMEOUT idle cycles.
    cyc();
    frame(60); frame(60); frame(60); frame(60);
    k = 0;
    while (k < TIMEOUT + 50 && !cmd_valid) begin
      cyc();
      k++;
    end
    check("tmo_cycles", k, TIMEOUT);
    check("tmo_valid", cmd_valid, 1);
    check("tmo_code", cmd_code, 0);
    check("tmo_frames", cmd_frames, 4);
    check("tmo_active", whistle_active, 0);

    // Reset mid-event with a command pending.
    hits(3, 60);
    check("midrst_active_pre", whistle_active, 1);
    reset = 1'b1;
    #2;
    check("midrst_valid", cmd_valid, 0);
    check("midrst_active", whistle_active, 0);
    check("midrst_frames", cmd_frames, 0);
    check("midrst_code", cmd_code, 0);
    cyc();
    reset = 1'b0;
    cyc();
    hits(5, 60);
    misses3();
    check("postrst_valid", cmd_valid, 1);
    check("postrst_frames", cmd_frames, 5);
    accept();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
